// File: rtl/csr_timer_pkg.sv
// Shared constants, field positions and helpers for the CSR countdown timer.
package csr_timer_pkg;

  localparam int unsigned CSR_NUM_W  = 14;
  localparam int unsigned CSR_DATA_W = 32;

  localparam logic [CSR_NUM_W-1:0] CSR_TID   = 14'h040;
  localparam logic [CSR_NUM_W-1:0] CSR_TCFG  = 14'h041;
  localparam logic [CSR_NUM_W-1:0] CSR_TVAL  = 14'h042;
  localparam logic [CSR_NUM_W-1:0] CSR_TICLR = 14'h044;

  localparam int unsigned TCFG_EN          = 0;
  localparam int unsigned TCFG_PERIODIC    = 1;
  localparam int unsigned TCFG_INITVAL_LSB = 2;
  localparam int unsigned TICLR_CLR        = 0;

  typedef logic [CSR_DATA_W-1:0] csr_data_t;

  // Bits outside wmask keep their old value.
  function automatic csr_data_t masked_write(input csr_data_t old_v,
                                             input csr_data_t wmask,
                                             input csr_data_t wvalue);
    return (old_v & ~wmask) | (wvalue & wmask);
  endfunction

endpackage

// File: rtl/csr_timer_if.sv
// CSR read/write bus between the CSR file (master) and the timer (slave).
interface csr_timer_if;
  import csr_timer_pkg::*;

  logic                  csr_we;
  logic [CSR_NUM_W-1:0]  csr_wnum;
  logic [CSR_DATA_W-1:0] csr_wmask;
  logic [CSR_DATA_W-1:0] csr_wvalue;
  logic [CSR_NUM_W-1:0]  csr_rnum;
  logic [CSR_DATA_W-1:0] csr_rvalue;

  modport master (
    output csr_we, csr_wnum, csr_wmask, csr_wvalue, csr_rnum,
    input  csr_rvalue
  );

  modport slave (
    input  csr_we, csr_wnum, csr_wmask, csr_wvalue, csr_rnum,
    output csr_rvalue
  );

endinterface

// File: rtl/csr_timer_countdown.sv
// Countdown datapath: tval register, stopped flag, load/reload/decrement and expiry pulse.
module timer_countdown #(
  parameter int unsigned TIMER_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 halt,
  input  logic                 load_we,
  input  logic                 load_en,
  input  logic [TIMER_W-3:0]   load_initval,
  input  logic                 en,
  input  logic                 periodic,
  input  logic [TIMER_W-3:0]   initval,
  output logic [TIMER_W-1:0]   tval,
  output logic                 expire_c
);

  logic [TIMER_W-1:0] tval_nxt;
  logic               stopped;
  logic               stopped_nxt;

  // A TCFG write pre-empts counting for the cycle it lands in.
  always_comb begin
    tval_nxt    = tval;
    stopped_nxt = stopped;
    expire_c    = 1'b0;
    if (load_we) begin
      stopped_nxt = 1'b0;
      if (load_en) begin
        tval_nxt = {load_initval, 2'b00};
      end
    end else if (en && !stopped && !halt) begin
      if (tval != '0) begin
        tval_nxt = tval - TIMER_W'(1);
      end else begin
        expire_c = 1'b1;
        if (periodic) begin
          tval_nxt = {initval, 2'b00};
        end else begin
          tval_nxt    = '1;
          stopped_nxt = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tval    <= '1;
      stopped <= 1'b1;
    end else begin
      tval    <= tval_nxt;
      stopped <= stopped_nxt;
    end
  end

endmodule

// File: rtl/csr_timer.sv
// CSR-mapped countdown timer: TID/TCFG/TVAL/TICLR, timer interrupt and rdcntid value.
// Optional build macro CSR_TIMER_HALT_EN adds a timer_halt input that freezes the countdown.
module csr_timer
  import csr_timer_pkg::*;
#(
  parameter int unsigned     TIMER_W   = 32,
  parameter logic [31:0]     TID_RESET = 32'h0
) (
  input  logic              clk,
  input  logic              reset,
`ifdef CSR_TIMER_HALT_EN
  input  logic              timer_halt,
`endif
  csr_timer_if.slave        csr,
  output logic              timer_int,
  output logic [31:0]       tid_value
);

  logic [TIMER_W-1:0]    tcfg;
  logic [CSR_DATA_W-1:0] tid;
  logic                  ti;

  logic                  wr_tid;
  logic                  wr_tcfg;
  logic                  ticlr_clr;
  logic [CSR_DATA_W-1:0] tcfg_wfull;
  logic [TIMER_W-1:0]    tcfg_new;
  logic [TIMER_W-1:0]    tval;
  logic                  expire_c;
  logic                  halt;

`ifdef CSR_TIMER_HALT_EN
  assign halt = timer_halt;
`else
  assign halt = 1'b0;
`endif

  // Write decode; TVAL is read-only so it has no write strobe.
  assign wr_tid     = csr.csr_we && (csr.csr_wnum == CSR_TID);
  assign wr_tcfg    = csr.csr_we && (csr.csr_wnum == CSR_TCFG);
  assign ticlr_clr  = csr.csr_we && (csr.csr_wnum == CSR_TICLR)
                      && csr.csr_wmask[TICLR_CLR] && csr.csr_wvalue[TICLR_CLR];
  assign tcfg_wfull = masked_write(CSR_DATA_W'(tcfg), csr.csr_wmask, csr.csr_wvalue);
  assign tcfg_new   = tcfg_wfull[TIMER_W-1:0];

  timer_countdown #(
    .TIMER_W (TIMER_W)
  ) u_countdown (
    .clk          (clk),
    .reset        (reset),
    .halt         (halt),
    .load_we      (wr_tcfg),
    .load_en      (tcfg_new[TCFG_EN]),
    .load_initval (tcfg_new[TIMER_W-1:TCFG_INITVAL_LSB]),
    .en           (tcfg[TCFG_EN]),
    .periodic     (tcfg[TCFG_PERIODIC]),
    .initval      (tcfg[TIMER_W-1:TCFG_INITVAL_LSB]),
    .tval         (tval),
    .expire_c     (expire_c)
  );

  // Expiry set has priority over a same-cycle TICLR clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      tcfg <= '0;
      tid  <= TID_RESET;
      ti   <= 1'b0;
    end else begin
      if (wr_tid) begin
        tid <= masked_write(tid, csr.csr_wmask, csr.csr_wvalue);
      end
      if (wr_tcfg) begin
        tcfg <= tcfg_new;
      end
      if (expire_c) begin
        ti <= 1'b1;
      end else if (ticlr_clr) begin
        ti <= 1'b0;
      end
    end
  end

  assign timer_int = ti;
  assign tid_value = tid;

  // Read mux reflects current register contents, so same-cycle writes read old data.
  always_comb begin
    csr.csr_rvalue = '0;
    case (csr.csr_rnum)
      CSR_TID:  csr.csr_rvalue = tid;
      CSR_TCFG: csr.csr_rvalue = CSR_DATA_W'(tcfg);
      CSR_TVAL: csr.csr_rvalue = CSR_DATA_W'(tval);
      default:  csr.csr_rvalue = '0;
    endcase
  end

endmodule

// File: tb/tb_csr_timer.sv
// Directed self-checking bench for csr_timer; exercises halt when CSR_TIMER_HALT_EN is defined.
module tb_csr_timer;
  import csr_timer_pkg::*;

  localparam logic [31:0] TID_RST = 32'hCAFE_0000;

  logic clk;
  logic reset;
  logic timer_int;
  logic [31:0] tid_value;
`ifdef CSR_TIMER_HALT_EN
  logic timer_halt;
`endif

  int total;
  int bad;

  csr_timer_if bus ();

  csr_timer #(
    .TIMER_W   (32),
    .TID_RESET (TID_RST)
  ) dut (
    .clk        (clk),
    .reset      (reset),
`ifdef CSR_TIMER_HALT_EN
    .timer_halt (timer_halt),
`endif
    .csr        (bus),
    .timer_int  (timer_int),
    .tid_value  (tid_value)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rd(input logic [13:0] num, input logic [31:0] exp, input string tag);
    bus.csr_rnum = num;
    #1;
    check(tag, bus.csr_rvalue, exp);
  endtask

  task automatic csr_write(input logic [13:0] num, input logic [31:0] mask, input logic [31:0] val);
    bus.csr_we     = 1'b1;
    bus.csr_wnum   = num;
    bus.csr_wmask  = mask;
    bus.csr_wvalue = val;
    tick(1);
    bus.csr_we     = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus.csr_we = 1'b0;
    bus.csr_wnum = '0;
    bus.csr_wmask = '0;
    bus.csr_wvalue = '0;
    bus.csr_rnum = '0;
`ifdef CSR_TIMER_HALT_EN
    timer_halt = 1'b0;
`endif
    tick(2);
    reset = 1'b0;

    // Reset state
    rd(CSR_TID, TID_RST, "rst_tid");
    rd(CSR_TCFG, 32'h0, "rst_tcfg");
    rd(CSR_TVAL, 32'hFFFF_FFFF, "rst_tval");
    rd(CSR_TICLR, 32'h0, "rst_ticlr");
    rd(14'h043, 32'h0, "rst_unmapped");
    check("rst_int", 32'(timer_int), 32'h0);
    check("rst_tid_value", tid_value, TID_RST);

    // One-shot, InitVal 4: loads 0x10, expires 17 edges after the load
    csr_write(CSR_TCFG, 32'hFFFF_FFFF, 32'h11);
    rd(CSR_TVAL, 32'h10, "os_load");
    rd(CSR_TCFG, 32'h11, "os_tcfg");
    tick(8);
    rd(CSR_TVAL, 32'h8, "os_mid");
    tick(8);
    rd(CSR_TVAL, 32'h0, "os_zero");
    check("os_int_pre", 32'(timer_int), 32'h0);
    tick(1);
    check("os_int_set", 32'(timer_int), 32'h1);
    rd(CSR_TVAL, 32'hFFFF_FFFF, "os_stop_val");
    tick(50);
    rd(CSR_TVAL, 32'hFFFF_FFFF, "os_hold");
    check("os_int_hold", 32'(timer_int), 32'h1);

    // TICLR clears pending interrupt
    csr_write(CSR_TICLR, 32'hFFFF_FFFF, 32'h1);
    check("clr_int", 32'(timer_int), 32'h0);

    // Periodic, InitVal 2: period of 9 cycles
    csr_write(CSR_TCFG, 32'hFFFF_FFFF, 32'h0B);
    rd(CSR_TVAL, 32'h8, "per_load");
    tick(8);
    rd(CSR_TVAL, 32'h0, "per_zero");
    check("per_int_pre", 32'(timer_int), 32'h0);
    tick(1);
    check("per_int_set", 32'(timer_int), 32'h1);
    rd(CSR_TVAL, 32'h8, "per_reload");
    csr_write(CSR_TICLR, 32'h1, 32'h1);
    check("per_clr", 32'(timer_int), 32'h0);
    rd(CSR_TVAL, 32'h7, "per_after_clr");
    tick(7);
    check("per_int_still_clr", 32'(timer_int), 32'h0);
    tick(1);
    check("per_int_reassert", 32'(timer_int), 32'h1);

    // TICLR in the expiry cycle: set wins
    csr_write(CSR_TICLR, 32'h1, 32'h1);
    check("race_pre_clr", 32'(timer_int), 32'h0);
    tick(7);
    rd(CSR_TVAL, 32'h0, "race_zero");
    csr_write(CSR_TICLR, 32'h1, 32'h1);
    check("race_set_wins", 32'(timer_int), 32'h1);
    rd(CSR_TVAL, 32'h8, "race_reload");

    // TCFG write in the expiry cycle: no ti set
    csr_write(CSR_TICLR, 32'h1, 32'h1);
    tick(7);
    rd(CSR_TVAL, 32'h0, "tcfgrace_zero");
    csr_write(CSR_TCFG, 32'hFFFF_FFFF, 32'h0B);
    check("tcfgrace_no_int", 32'(timer_int), 32'h0);
    rd(CSR_TVAL, 32'h8, "tcfgrace_reload");

    // En=0 holds tval; TVAL writes ignored; masked TID write with same-cycle old read
    csr_write(CSR_TCFG, 32'hFFFF_FFFF, 32'h0);
    rd(CSR_TVAL, 32'h8, "dis_hold");
    tick(5);
    rd(CSR_TVAL, 32'h8, "dis_hold_later");
    csr_write(CSR_TVAL, 32'hFFFF_FFFF, 32'h1234);
    rd(CSR_TVAL, 32'h8, "tval_ro");
    bus.csr_we     = 1'b1;
    bus.csr_wnum   = CSR_TID;
    bus.csr_wmask  = 32'h0000_FFFF;
    bus.csr_wvalue = 32'hABCD_5678;
    rd(CSR_TID, TID_RST, "tid_old_read");
    tick(1);
    bus.csr_we = 1'b0;
    rd(CSR_TID, 32'hCAFE_5678, "tid_masked");
    check("tid_value", tid_value, 32'hCAFE_5678);
    csr_write(CSR_TCFG, 32'h0000_0002, 32'hFFFF_FFFF);
    rd(CSR_TCFG, 32'h2, "tcfg_masked");

    // Reset mid-count with pending ti
    csr_write(CSR_TCFG, 32'hFFFF_FFFF, 32'h0B);
    tick(9);
    check("mid_int_set", 32'(timer_int), 32'h1);
    tick(2);
    rd(CSR_TVAL, 32'h6, "mid_count");
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    rd(CSR_TVAL, 32'hFFFF_FFFF, "mid_rst_tval");
    rd(CSR_TCFG, 32'h0, "mid_rst_tcfg");
    rd(CSR_TID, TID_RST, "mid_rst_tid");
    check("mid_rst_int", 32'(timer_int), 32'h0);

`ifdef CSR_TIMER_HALT_EN
    // Halt for 10 cycles delays expiry by exactly 10
    csr_write(CSR_TCFG, 32'hFFFF_FFFF, 32'h11);
    tick(4);
    rd(CSR_TVAL, 32'hC, "halt_pre");
    timer_halt = 1'b1;
    tick(10);
    rd(CSR_TVAL, 32'hC, "halt_frozen");
    timer_halt = 1'b0;
    tick(12);
    rd(CSR_TVAL, 32'h0, "halt_zero");
    check("halt_int_pre", 32'(timer_int), 32'h0);
    tick(1);
    check("halt_int_set", 32'(timer_int), 32'h1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/csr_timer.md
Name: csr_timer

Overview:
CSR-mapped countdown timer for the CPU core. It implements the TID, TCFG, TVAL and TICLR control/status registers. It sits beside the free-running 64-bit stable counter and supplies two things to the rest of the core: the timer interrupt line for the ESTAT/exception logic, and the counter ID returned by rdcntid. The CSR file forwards the timer-range read/write traffic to this block.

Parameters:
TIMER_W, 32, countdown width in bits. Legal range 8..32; bits above TIMER_W read as 0.
TID_RESET, 32'h0, reset value of TID.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
csr_we  in  1  CSR write strobe, valid for one cycle
csr_wnum  in  14  CSR write address
csr_wmask  in  32  per-bit write mask
csr_wvalue  in  32  write data
csr_rnum  in  14  CSR read address
csr_rvalue  out  32  read data, combinational from csr_rnum
timer_int  out  1  registered timer-interrupt pending (TI)
tid_value  out  32  current TID, for rdcntid

Behaviour:
- Reset is synchronous, active-high, on clock clk. Reset values:
  - tcfg = 0
  - tval = all-ones
  - stopped = 1
  - ti = 0, so timer_int = 0
  - tid = TID_RESET
- CSR map (package constants): TID 0x40, TCFG 0x41, TVAL 0x42, TICLR 0x44.
- Masked write rule: new = (old & ~wmask) | (wvalue & wmask).
- TID: fully writable.
- TCFG fields:
  - bit0 En
  - bit1 Periodic
  - [TIMER_W-1:2] InitVal
  - bits above TIMER_W are read-only 0.
- Any TCFG write:
  - Takes effect next cycle.
  - Clears stopped.
  - If the new En = 1, loads tval <= {new InitVal, 2'b00}; counting starts the following cycle.
  - If the new En = 0, tval holds its value.
- TVAL is read-only; writes are ignored.
- TICLR: writing 1 to bit0 under the mask clears ti next cycle. TICLR always reads 0.
- Countdown, evaluated each cycle when En = 1, stopped = 0, and no TCFG write this cycle:
  - tval != 0: tval <= tval - 1.
  - tval == 0: ti <= 1, then:
    - Periodic = 1: reload tval <= {InitVal, 2'b00}.
    - Periodic = 0: tval <= all-ones and stopped <= 1. It stays there until the next TCFG write.
- Periodic with InitVal = 0: expires every cycle; ti stays set.
- Simultaneous expiry and TICLR clear in the same cycle: set wins and ti stays 1.
- Simultaneous TCFG write and expiry: the TCFG write wins, and no ti set occurs that cycle.
- Reads:
  - Same-cycle read of a register being written returns the old value.
  - Unmapped csr_rnum returns 0.
- timer_int equals ti directly, with no extra flop stage. tid_value equals tid.
- Reset mid-count drops the count immediately and clears any pending ti.

Optional Feature:
Macro CSR_TIMER_HALT_EN.
- Defined: adds input port timer_halt (1 bit). While it is 1, tval is frozen, no expiry is evaluated, and ti holds its value. CSR writes and TICLR still take effect.
- Undefined: the port is absent and countdown is never frozen.

Decomposition:
- Package csr_timer_pkg holds:
  - the CSR number constants for TID, TCFG, TVAL and TICLR
  - TCFG field bit positions: EN=0, PERIODIC=1, INITVAL_LSB=2
  - the TICLR_CLR bit position.
- One sub-module, timer_countdown, is natural. It contains the tval register, stopped flag, reload/decrement logic and the expire pulse output. The top level holds the CSR decode, tcfg, tid, ti and the read mux.

Test Plan:
1. Reset, then read all four CSRs -> TID = TID_RESET, TCFG = 0, TVAL = 0xFFFFFFFF, TICLR = 0; timer_int = 0.
2. Write TCFG = 0x11 (En, one-shot, InitVal 4) -> TVAL reads 0x10 next cycle, decrements to 0 over 16 cycles. timer_int rises the cycle after TVAL = 0 is evaluated. TVAL then reads 0xFFFFFFFF and is held for 50 more cycles.
3. Write TCFG = 0x0B (En, periodic, InitVal 2) -> timer_int asserts every 9 cycles. TICLR write 0x1 clears it; it re-asserts at the next expiry.
4. Issue a TICLR clear in the exact cycle TVAL = 0 with periodic on -> timer_int remains 1.
5. Write TVAL = 0x1234 and a TID write with mask 0x0000FFFF, wvalue 0xABCD5678 -> TVAL is unchanged; TID = {TID_RESET[31:16], 16'h5678}; tid_value matches.
6. With CSR_TIMER_HALT_EN defined, assert timer_halt for 10 cycles mid-count -> TVAL is frozen, and expiry is delayed by exactly 10 cycles.
